// File: rtl/iot_filter_param.sv
// iot_filter_param: assembles BW-bit beats into DW-bit words and filters
// rounds of NW words (max/min/avg/window/peak), one result pulse per hit.
//
// Ports:
//   clk, rst_n        clock, async active-low reset
//   in_en, iot_in     beat strobe and beat data (MSB slice first)
//   fn_sel            function select, latched at word 0 of each round
//   thr_lo, thr_hi    unsigned thresholds, latched with fn_sel
//   busy              high while beats are not accepted
//   valid, iot_out    one-cycle result pulse and held result word
module iot_filter_param #(
    parameter int DW = 128,
    parameter int BW = 8,
    parameter int NW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_en,
    input  logic [BW-1:0] iot_in,
    input  logic [2:0]    fn_sel,
    input  logic [DW-1:0] thr_lo,
    input  logic [DW-1:0] thr_hi,
    output logic          busy,
    output logic          valid,
    output logic [DW-1:0] iot_out
);

    localparam int NB  = DW / BW;
    localparam int BCW = (NB > 1) ? $clog2(NB) : 1;
    localparam int LN  = $clog2(NW);
    localparam int AW  = DW + LN;

    typedef enum logic [1:0] {IDLE, COLLECT, EVAL} state_t;

    state_t         state, state_nxt;
    logic [BCW-1:0] bcnt;
    logic [LN-1:0]  wcnt;
    logic [DW-1:0]  word, word_nxt;
    logic [DW-1:0]  run_max, run_min, peak;
    logic [DW-1:0]  lo_q, hi_q;
    logic [AW-1:0]  acc, acc_n;
    logic [2:0]     fn_q;
    logic           peak_vld;

    logic          accept, last_beat, first, last;
    logic [2:0]    fn_e;
    logic [DW-1:0] lo_e, hi_e;
    logic [DW-1:0] cmax, cmin;
    logic          pv_e;
    logic          hit, peak_upd;
    logic [DW-1:0] out_nxt;

    assign busy      = (state != COLLECT);
    assign accept    = in_en && (state == COLLECT);
    assign last_beat = (bcnt == BCW'(NB - 1));
    assign word_nxt  = (word << BW) | DW'(iot_in);

    assign first = (wcnt == '0);
    assign last  = (wcnt == LN'(NW - 1));

    // Word 0 evaluates with the values being latched on this same edge.
    assign fn_e = first ? fn_sel : fn_q;
    assign lo_e = first ? thr_lo : lo_q;
    assign hi_e = first ? thr_hi : hi_q;

    assign cmax  = (first || word > run_max) ? word : run_max;
    assign cmin  = (first || word < run_min) ? word : run_min;
    assign acc_n = (first ? '0 : acc) + AW'(word);

    // A mode change at round start invalidates the stored peak.
    assign pv_e = (first && fn_sel != fn_q) ? 1'b0 : peak_vld;

    always_comb begin
        state_nxt = state;
        hit       = 1'b0;
        peak_upd  = 1'b0;
        out_nxt   = word;
        unique case (state)
            IDLE:    state_nxt = COLLECT;
            COLLECT: if (accept && last_beat) state_nxt = EVAL;
            EVAL: begin
                state_nxt = COLLECT;
                case (fn_e)
                    3'd1: if (last) begin
                        hit     = 1'b1;
                        out_nxt = cmax;
                    end
                    3'd2: if (last) begin
                        hit     = 1'b1;
                        out_nxt = cmin;
                    end
                    3'd3: if (last) begin
                        hit     = 1'b1;
                        out_nxt = DW'(acc_n >> LN);
                    end
                    3'd4: hit = (word > lo_e) && (word < hi_e);
                    3'd5: hit = (word < lo_e) || (word > hi_e);
                    3'd6: if (last && (!pv_e || cmax > peak)) begin
                        hit      = 1'b1;
                        peak_upd = 1'b1;
                        out_nxt  = cmax;
                    end
                    3'd7: if (last && (!pv_e || cmin < peak)) begin
                        hit      = 1'b1;
                        peak_upd = 1'b1;
                        out_nxt  = cmin;
                    end
                    default: ;
                endcase
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            bcnt     <= '0;
            wcnt     <= '0;
            word     <= '0;
            run_max  <= '0;
            run_min  <= '0;
            peak     <= '0;
            peak_vld <= 1'b0;
            acc      <= '0;
            fn_q     <= '0;
            lo_q     <= '0;
            hi_q     <= '0;
            valid    <= 1'b0;
            iot_out  <= '0;
        end else begin
            state <= state_nxt;
            valid <= hit;
            if (hit) iot_out <= out_nxt;
            if (accept) begin
                word <= word_nxt;
                bcnt <= last_beat ? '0 : bcnt + BCW'(1);
            end
            if (state == EVAL) begin
                wcnt     <= wcnt + LN'(1);
                run_max  <= cmax;
                run_min  <= cmin;
                acc      <= last ? '0 : acc_n;
                peak_vld <= pv_e | peak_upd;
                if (peak_upd) peak <= out_nxt;
                if (first) begin
                    fn_q <= fn_sel;
                    lo_q <= thr_lo;
                    hi_q <= thr_hi;
                end
            end
        end
    end

endmodule

// File: tb/tb_iot_filter_param.sv
// tb_iot_filter_param: directed rounds with hand-computed results for
// iot_filter_param at default parameters (128-bit words, 8-bit beats, 8 words).
module tb_iot_filter_param;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_en = 1'b0;
    logic [7:0]   iot_in = '0;
    logic [2:0]   fn_sel = '0;
    logic [127:0] thr_lo = '0;
    logic [127:0] thr_hi = '0;
    logic         busy, valid;
    logic [127:0] iot_out;

    iot_filter_param dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .in_en  (in_en),
        .iot_in (iot_in),
        .fn_sel (fn_sel),
        .thr_lo (thr_lo),
        .thr_hi (thr_hi),
        .busy   (busy),
        .valid  (valid),
        .iot_out(iot_out)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;
    logic [127:0] q[$];
    logic [127:0] wv[8];
    logic prev_v = 1'b0;

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    always @(negedge clk) begin
        if (valid) begin
            q.push_back(iot_out);
            chk("single_pulse", 128'(prev_v), 128'd0);
        end
        prev_v = valid;
    end

    // While busy, a junk beat is driven with in_en high; it must be dropped.
    task automatic send_beats(input logic [127:0] w, input int n);
        int i = 0;
        int guard = 0;
        while (i < n) begin
            @(negedge clk);
            in_en = 1'b1;
            if (busy) iot_in = 8'hA5;
            else begin
                iot_in = w[127-8*i -: 8];
                i++;
            end
            guard++;
            if (guard > 64) begin
                chk("beat_timeout", 128'd1, 128'd0);
                break;
            end
        end
    endtask

    task automatic run_round(input int mid_fn);
        q.delete();
        for (int k = 0; k < 8; k++) begin
            send_beats(wv[k], 16);
            if (k == 2 && mid_fn >= 0) fn_sel = 3'(mid_fn);
        end
        @(negedge clk);
        in_en = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic check_round(input string tag, input int n,
                               input logic [127:0] e0,
                               input logic [127:0] e1,
                               input logic [127:0] e2,
                               input logic [127:0] hold);
        logic [127:0] e[3];
        e = '{e0, e1, e2};
        chk({tag, "_count"}, 128'(q.size()), 128'(n));
        for (int k = 0; k < n; k++)
            chk($sformatf("%s_val%0d", tag, k),
                (q.size() > k) ? q[k] : 'x, e[k]);
        chk({tag, "_hold"}, iot_out, hold);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_busy", 128'(busy), 128'd1);
        chk("rst_valid", 128'(valid), 128'd0);
        chk("rst_out", iot_out, 128'd0);
        rst_n = 1'b1;
        #1;
        chk("idle_busy", 128'(busy), 128'd1);

        fn_sel = 3'd1;
        wv = '{128'd1, 128'd2, 128'd3, 128'd4,
               128'd5, 128'd6, 128'd7, 128'd8};
        run_round(2);
        check_round("max", 1, 128'd8, 0, 0, 128'd8);

        fn_sel = 3'd2;
        run_round(-1);
        check_round("min", 1, 128'd1, 0, 0, 128'd1);

        fn_sel = 3'd3;
        wv = '{128'd1, 128'd2, 128'd3, 128'd4,
               128'd5, 128'd6, 128'd7, 128'd9};
        run_round(-1);
        check_round("avg", 1, 128'd4, 0, 0, 128'd4);
        wv = '{'1, '1, '1, '1, '1, '1, '1, '1};
        run_round(-1);
        check_round("avg_ones", 1, '1, 0, 0, '1);

        fn_sel = 3'd4;
        thr_lo = 128'd10;
        thr_hi = 128'd20;
        wv = '{128'd9, 128'd10, 128'd11, 128'd19,
               128'd20, 128'd21, 128'd15, 128'd0};
        run_round(-1);
        check_round("extract", 3, 128'd11, 128'd19, 128'd15, 128'd15);
        fn_sel = 3'd5;
        run_round(-1);
        check_round("exclude", 3, 128'd9, 128'd21, 128'd0, 128'd0);

        fn_sel = 3'd6;
        wv = '{128'd50, 128'd1, 128'd2, 128'd3,
               128'd4, 128'd5, 128'd6, 128'd7};
        run_round(-1);
        check_round("peak_r1", 1, 128'd50, 0, 0, 128'd50);
        wv[0] = 128'd40;
        run_round(-1);
        check_round("peak_r2", 0, 0, 0, 0, 128'd50);
        wv[0] = 128'd60;
        run_round(-1);
        check_round("peak_r3", 1, 128'd60, 0, 0, 128'd60);
        wv[0] = 128'd1;
        wv[2] = 128'd60;
        run_round(-1);
        check_round("peak_r4", 0, 0, 0, 0, 128'd60);

        fn_sel = 3'd7;
        wv = '{128'd100, 128'd200, 128'd150, 128'd300,
               128'd120, 128'd110, 128'd400, 128'd101};
        run_round(-1);
        check_round("peakmin", 1, 128'd100, 0, 0, 128'd100);

        fn_sel = 3'd1;
        q.delete();
        send_beats(128'd9, 16);
        send_beats(128'd9, 16);
        send_beats(128'd9, 16);
        send_beats(128'hFFFF, 5);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_busy", 128'(busy), 128'd1);
        chk("mid_valid", 128'(valid), 128'd0);
        chk("mid_out", iot_out, 128'd0);
        @(negedge clk);
        in_en = 1'b0;
        rst_n = 1'b1;
        #1;
        chk("mid_idle_busy", 128'(busy), 128'd1);
        chk("mid_no_valid", 128'(q.size()), 128'd0);

        wv = '{128'd1, 128'd2, 128'd3, 128'd4,
               128'd5, 128'd6, 128'd7, 128'd8};
        run_round(-1);
        check_round("post_rst", 1, 128'd8, 0, 0, 128'd8);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/iot_filter_param.md
IOT_FILTER_PARAM -- requirements
Module: iot_filter_param

Interface
REQ-001 Parameter DW, default 128: data word width in bits; SHALL be a multiple of BW.
REQ-002 Parameter BW, default 8: input beat width in bits.
REQ-003 Parameter NW, default 8: words per round; SHALL be a power of two, >= 2.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 in_en  input  1  beat strobe; beat accepted when in_en=1 and busy=0.
REQ-007 iot_in  input  BW  data beat; first beat of a word is the MSB slice.
REQ-008 fn_sel  input  3  function select: 0 reserved, 1 MAX, 2 MIN, 3 AVG, 4 EXTRACT, 5 EXCLUDE, 6 PEAKMAX, 7 PEAKMIN.
REQ-009 thr_lo  input  DW  runtime lower threshold, unsigned.
REQ-010 thr_hi  input  DW  runtime upper threshold, unsigned.
REQ-011 busy  output  1  1 = beats not accepted.
REQ-012 valid  output  1  one-cycle pulse qualifying iot_out.
REQ-013 iot_out  output  DW  result word, unsigned.

Function
REQ-014 FSM states IDLE, COLLECT, EVAL; IDLE->COLLECT unconditionally after one cycle; COLLECT->EVAL on acceptance of beat DW/BW-1 of a word; EVAL->COLLECT unconditionally.
REQ-015 busy SHALL be 1 in IDLE and EVAL and 0 in COLLECT; in_en while busy=1 SHALL be ignored (beat dropped, no counter change).
REQ-016 Beat counter SHALL run 0..DW/BW-1 and wrap; word counter SHALL run 0..NW-1, increment in EVAL, wrap to 0 after NW-1 (round end).
REQ-017 Word w evaluated in EVAL; all comparisons unsigned, full DW width; result registered so valid/iot_out update on the edge ending EVAL (latency 1 cycle from last beat accept to valid).
REQ-018 fn_sel and thresholds SHALL be latched in EVAL of word 0; values changed mid-round SHALL be ignored until the next round.
REQ-019 MAX/MIN: running extreme over the round; valid=1 only at round end with the round max/min.
REQ-020 AVG: accumulator DW+log2(NW) bits; at round end iot_out = floor(sum/NW) (right shift log2(NW)), valid=1; accumulator cleared for next round.
REQ-021 EXTRACT: valid=1, iot_out=w for each word with thr_lo < w < thr_hi (strict).
REQ-022 EXCLUDE: valid=1, iot_out=w for each word with w < thr_lo or w > thr_hi (strict).
REQ-023 PEAKMAX: at round end, if first round since reset/mode change or round max > stored peak (strict), peak := round max, iot_out=peak, valid=1; else no valid.
REQ-024 PEAKMIN: as REQ-023 with round min and strict less-than.
REQ-025 Peak register SHALL be invalidated when latched fn_sel differs from previous round's.
REQ-026 fn_sel=0: no valid; iot_out holds.
REQ-027 iot_out SHALL hold its last value when valid=0; valid SHALL never be high two consecutive cycles.

Reset
REQ-028 On rst_n=0 (any time, including mid-word or mid-round): state IDLE, busy=1, valid=0, iot_out=0, all counters, partial word, accumulator, running extremes and peak cleared/invalidated.
REQ-029 After rst_n release, first beat accepted no earlier than the second rising edge (one IDLE cycle).

Verification
REQ-030 Defaults, fn_sel=1, words 1..8 (word k = k) -> single valid at word 8 EVAL, iot_out=8; fn_sel=2 same data -> iot_out=1.
REQ-031 fn_sel=3, words 1,2,3,4,5,6,7,9 -> iot_out=4 (sum 37, floor 37/8); all-ones words x8 -> iot_out=all-ones (no overflow).
REQ-032 fn_sel=4, thr_lo=10, thr_hi=20, words 9,10,11,19,20,21,15,0 -> exactly 3 valids, iot_out 11,19,15; fn_sel=5 same data -> valids for 9,21,0.
REQ-033 fn_sel=6, round maxima 50,40,60,60 -> valid after rounds 1 and 3 only (50, 60); switch to fn_sel=7 -> valid after next round regardless of value.
REQ-034 in_en held high continuously -> beats during EVAL/IDLE dropped, word assembly uses only accepted beats; rst_n pulsed low after 5 beats of word 3 -> busy=1, valid=0, iot_out=0, next round starts at word 0, beat 0.
